weight_mem_streamer: RTL and testbench
======================================

Name: weight_mem_streamer

Overview:
- Memory-side responder for the weight-buffer load interface. It answers the buffer's mem_req with a stream of 64-bit mem_data_valid/weight_data beats.
- It reads weights from the on-chip weight SRAM, which has a 1-cycle read latency, starting at a programmed base word address.
- In MODE1/MODE2 the SRAM holds 11-byte filter rows packed back to back. The block realigns them into the buffer's 2-beat-per-row format.
- In MODE3/MODE4 each row is one aligned SRAM word, passed through unchanged.

Parameters:
- ADDR_W, 16, SRAM word-address width.
- ROWS_M12, 43, rows streamed in MODE1/MODE2.
- ROWS_M3, 19, rows streamed in MODE3.
- ROWS_M4, 11, rows streamed in MODE4.
- ROW_BYTES_M12, 11, bytes per packed row in MODE1/MODE2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches mode_in and base_addr and begins a transfer.
- mode_in  in  OP_MODE  layer mode for the transfer.
- base_addr  in  ADDR_W  first SRAM word address.
- mem_req  in  1  buffer wants data; a beat transfers on mem_data_valid && mem_req.
- free_weight_buffer  in  1  buffer flush; aborts any transfer in progress.
- mem_data_valid  out  1  weight_data holds a valid beat.
- weight_data  out  64  beat payload; the first byte in stream order sits in [63:56].
- sram_rd_en  out  1  SRAM read strobe.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_rd_data  in  64  SRAM data, valid the cycle after sram_rd_en.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst_n=1): state IDLE; mem_data_valid=0, weight_data=0, sram_rd_en=0, sram_addr=0, busy=0, done=0; byte store and all counters cleared.
- SRAM byte order: the lowest byte address of a word is bits [63:56].
- FSM states: IDLE, STREAM, FINISH.
  - IDLE to STREAM on start. Latch cur_mode and addr=base_addr; busy=1 from the next cycle.
  - STREAM to FINISH when the last beat handshakes.
  - FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
  - start while busy is ignored.
  - free_weight_buffer in any state returns to IDLE next cycle. It clears mem_data_valid, the byte store and the counters, and no done pulse is produced. A read response still in flight is discarded.
- Beat format, MODE1/MODE2:
  - Row r is bytes 11r..11r+10 of the packed stream.
  - Beat 0 of a row carries row bytes 0..7 in [63:0].
  - Beat 1 carries row bytes 8..10 in [63:40], with [39:0]=0.
  - Total 2*ROWS_M12 = 86 beats from 473 bytes, i.e. 60 SRAM words. The unused tail of the last word is dropped.
- Beat format, MODE3/MODE4: one beat per row, equal to SRAM word base_addr+r. Totals are 19 beats (MODE3) and 11 beats (MODE4).
- Realignment store:
  - 16-byte shift store with a byte count.
  - A read is issued (sram_rd_en=1, addr++) only when count plus 8 × reads in flight ≤ 8, and words remain.
  - At most one read is outstanding per cycle.
  - The return is appended at the tail; beats are drained from the head.
- Output handshake:
  - The output register loads when it is empty, or being accepted this cycle, and the store holds enough bytes: 8 for beat 0, 3 for beat 1.
  - While mem_data_valid=1 && mem_req=0, weight_data and mem_data_valid hold stable.
  - Back-to-back: with mem_req held high, a beat is accepted every cycle after the pipeline fills.
- Latency: first mem_data_valid is 2 cycles after start (read issue, then data return), 3 cycles in MODE1/MODE2 only if the store is short.
- Counters are sized for 86 beats (7 bits) and 60 words (6 bits), with no wrap. sram_addr wraps modulo 2^ADDR_W.
- Simultaneous start and free_weight_buffer: free wins, stay IDLE.
- mem_req high while IDLE has no effect; mem_data_valid stays 0.

Test Plan:
- Reset mid-STREAM (MODE3, after 5 beats) -> next cycle mem_data_valid=0, busy=0, sram_rd_en=0, no done; a new start then streams from base_addr again.
- MODE4, base=0x0100, SRAM[0x100+i]=i, mem_req=1 -> 11 beats with weight_data=0..10 on consecutive cycles, first at start+2; done pulses once; 11 reads issued.
- MODE1, base=0, SRAM byte k=k mod 256, mem_req=1 -> 86 beats:
  - beat0 = 0x0001020304050607, beat1 = 0x08090A0000000000;
  - beat2 = 0x0B0C0D0E0F101112, beat3 = 0x1314150000000000;
  - last beat (row 42 beat 1) = 0xD6D7D80000000000;
  - exactly 60 reads issued.
- MODE3 with mem_req toggled randomly (50%) -> 19 beats, data held stable while mem_req=0, no beat duplicated or skipped, done after the 19th handshake.
- free_weight_buffer at beat 30 of MODE2 -> immediate IDLE with no done; restart with start -> full 86-beat sequence correct from row 0.
- start pulsed while busy, and start together with free_weight_buffer -> both ignored; the transfer in progress is unaffected (first case) or the block stays IDLE (second case).

Source files
------------

// File: rtl/weight_mem_streamer.sv
// Weight SRAM responder for the weight-buffer load port. MODE1/2 (mode_in 0/1) repack 11-byte
// packed rows into two 64-bit beats per row; MODE3/4 (mode_in 2/3) pass one aligned word per row.
module weight_mem_streamer #(
  parameter int ADDR_W        = 16,
  parameter int ROWS_M12      = 43,
  parameter int ROWS_M3       = 19,
  parameter int ROWS_M4       = 11,
  parameter int ROW_BYTES_M12 = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode_in,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_req,
  input  logic              free_weight_buffer,
  output logic              mem_data_valid,
  output logic [63:0]       weight_data,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [63:0]       sram_rd_data,
  output logic              busy,
  output logic              done
);
  localparam int BEATS_M12  = 2 * ROWS_M12;
  localparam int WORDS_M12  = (ROWS_M12 * ROW_BYTES_M12 + 7) / 8;
  localparam int TAIL_BYTES = ROW_BYTES_M12 - 8;
  localparam int BEAT_W     = $clog2(BEATS_M12 + 1);
  localparam int WORD_W     = $clog2(WORDS_M12 + 1);
  localparam logic [63:0] TAIL_MASK = ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * TAIL_BYTES));
  localparam logic [3:0]  TAIL_NEED = 4'(TAIL_BYTES);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
  state_t state_reg, state_next;

  logic [1:0]        mode_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WORD_W-1:0] words_reg;
  logic [BEAT_W-1:0] loaded_reg, accepted_reg;
  logic [127:0]      store_reg;
  logic [4:0]        count_reg;
  logic              resp_reg;
  logic              out_valid_reg;
  logic [63:0]       out_data_reg;

  logic [BEAT_W-1:0] total_beats;
  logic [WORD_W-1:0] total_words;
  logic              accept, last_accept, start_go, issue, load, tail_phase;
  logic [4:0]        avail;
  logic [3:0]        need;
  logic [127:0]      combined;
  logic [63:0]       beat;

  always_comb begin
    total_beats = BEAT_W'(BEATS_M12);
    total_words = WORD_W'(WORDS_M12);
    if (mode_reg == 2'd2) begin
      total_beats = BEAT_W'(ROWS_M3);
      total_words = WORD_W'(ROWS_M3);
    end else if (mode_reg == 2'd3) begin
      total_beats = BEAT_W'(ROWS_M4);
      total_words = WORD_W'(ROWS_M4);
    end
  end

  assign accept      = out_valid_reg && mem_req;
  assign last_accept = accept && (accepted_reg == total_beats - BEAT_W'(1));

  // The response returning this cycle counts as the one read in flight.
  assign avail    = count_reg + (resp_reg ? 5'd8 : 5'd0);
  assign start_go = (state_reg == IDLE) && start && !free_weight_buffer && !rst_n;
  assign issue    = (state_reg == STREAM) && !free_weight_buffer && !rst_n &&
                    (words_reg < total_words) && (avail <= 5'd8);

  // First read goes out in the start cycle so the first beat is ready two cycles later.
  assign sram_rd_en = start_go || issue;
  assign sram_addr  = start_go ? base_addr : addr_reg;

  // Bytes beyond count_reg are always zero, so the returning word can be OR-ed in at the tail.
  assign combined   = store_reg | (resp_reg ? ({sram_rd_data, 64'd0} >> {count_reg, 3'b000}) : 128'd0);
  assign tail_phase = !mode_reg[1] && loaded_reg[0];
  assign need       = tail_phase ? TAIL_NEED : 4'd8;
  assign load       = (state_reg == STREAM) && (!out_valid_reg || accept) &&
                      (loaded_reg < total_beats) && (avail >= {1'b0, need});
  assign beat       = tail_phase ? (combined[127:64] & TAIL_MASK) : combined[127:64];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (last_accept) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (free_weight_buffer) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg     <= IDLE;
      mode_reg      <= 2'd0;
      addr_reg      <= '0;
      words_reg     <= '0;
      loaded_reg    <= '0;
      accepted_reg  <= '0;
      store_reg     <= '0;
      count_reg     <= '0;
      resp_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      resp_reg  <= sram_rd_en;
      if (sram_rd_en) addr_reg <= sram_addr + ADDR_W'(1);
      if (start_go) mode_reg <= mode_in;
      if (free_weight_buffer || state_reg != STREAM) begin
        store_reg     <= '0;
        count_reg     <= '0;
        out_valid_reg <= 1'b0;
        out_data_reg  <= '0;
        loaded_reg    <= '0;
        accepted_reg  <= '0;
        words_reg     <= start_go ? WORD_W'(1) : '0;
      end else begin
        words_reg <= words_reg + WORD_W'(issue);
        if (accept) accepted_reg <= accepted_reg + BEAT_W'(1);
        if (load) begin
          store_reg     <= combined << {need, 3'b000};
          count_reg     <= avail - {1'b0, need};
          out_data_reg  <= beat;
          out_valid_reg <= 1'b1;
          loaded_reg    <= loaded_reg + BEAT_W'(1);
        end else begin
          store_reg <= combined;
          count_reg <= avail;
          if (accept) out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign mem_data_valid = out_valid_reg;
  assign weight_data    = out_data_reg;
  assign busy           = (state_reg == STREAM);
  assign done           = (state_reg == FINISH);
endmodule

// File: tb/tb_weight_mem_streamer.sv
// Bench for weight_mem_streamer: directed and random transfers against a byte-stream
// reference built from the SRAM image.
module tb_weight_mem_streamer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode_in = 2'd0;
  logic [15:0] base_addr = 16'd0;
  logic        mem_req = 1'b0;
  logic        free_weight_buffer = 1'b0;
  logic        mem_data_valid;
  logic [63:0] weight_data;
  logic        sram_rd_en;
  logic [15:0] sram_addr;
  logic [63:0] sram_rd_data;
  logic        busy;
  logic        done;

  weight_mem_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in), .base_addr(base_addr),
    .mem_req(mem_req), .free_weight_buffer(free_weight_buffer),
    .mem_data_valid(mem_data_valid), .weight_data(weight_data),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rd_data(sram_rd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM image aliased on the low 8 address bits; one-cycle read latency.
  logic [63:0] mem [0:255];
  always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem[sram_addr[7:0]];

  int reads = 0;
  always @(posedge clk) if (sram_rd_en) reads++;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int exp_words;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sbyte(input logic [15:0] base, input int k);
    logic [63:0] w;
    logic [15:0] a;
    a = base + 16'(k / 8);
    w = mem[a[7:0]];
    return w[63 - 8 * (k % 8) -: 8];
  endfunction

  // Reference: MODE1/2 view the SRAM as a byte stream of 11-byte rows, MODE3/4 one word per row.
  task automatic build_exp(input logic [1:0] mode, input logic [15:0] base);
    logic [63:0] b0;
    logic [15:0] a;
    int rows;
    exp_q.delete();
    if (mode < 2) begin
      for (int r = 0; r < 43; r++) begin
        b0 = '0;
        for (int j = 0; j < 8; j++) b0 = {b0[55:0], sbyte(base, 11 * r + j)};
        exp_q.push_back(b0);
        exp_q.push_back({sbyte(base, 11 * r + 8), sbyte(base, 11 * r + 9), sbyte(base, 11 * r + 10), 40'h0});
      end
      exp_words = (43 * 11 + 7) / 8;
    end else begin
      rows = (mode == 2'd2) ? 19 : 11;
      for (int r = 0; r < rows; r++) begin
        a = base + 16'(r);
        exp_q.push_back(mem[a[7:0]]);
      end
      exp_words = rows;
    end
  endtask

  // abort_kind: 0 none, 1 free_weight_buffer, 2 reset, applied after abort_at beats.
  task automatic run(input logic [1:0] mode, input logic [15:0] base, input int req_pct,
                     input int abort_at, input int abort_kind, input int poke_t);
    int idx, dones, first_t;
    logic held;
    logic [63:0] held_data;
    build_exp(mode, base);
    got_q.delete();
    reads = 0;
    start = 1'b1; mode_in = mode; base_addr = base;
    mem_req = ($urandom_range(0, 99) < req_pct);
    #1;
    check("start_rd_en", sram_rd_en, 1'b1);
    check("start_addr", sram_addr, base);
    @(posedge clk); #1;
    start = 1'b0; mode_in = 2'($urandom); base_addr = 16'($urandom);
    idx = 0; dones = 0; first_t = -1; held = 1'b0; held_data = '0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (t == 0) check("busy_after_start", busy, 1'b1);
      if (held) begin
        check("hold_valid", mem_data_valid, 1'b1);
        check("hold_data", weight_data, held_data);
      end
      if (mem_data_valid && first_t < 0) begin
        first_t = t;
        check("first_latency", 64'(t), 64'd1);
      end
      if (mem_data_valid && mem_req) begin
        if (idx < exp_q.size()) check("beat_data", weight_data, exp_q[idx]);
        else check("extra_beat", 64'(idx), 64'(exp_q.size()));
        got_q.push_back(weight_data);
        idx++;
      end
      if (done) begin
        dones++;
        check("done_at_last", 64'(idx), 64'(exp_q.size()));
      end
      held = mem_data_valid && !mem_req;
      held_data = weight_data;
      if (abort_kind != 0 && idx == abort_at) break;
      if (dones > 0) break;
      @(posedge clk); #1;
      mem_req = ($urandom_range(0, 99) < req_pct);
      start = (t == poke_t);
      if (start) begin mode_in = 2'($urandom); base_addr = 16'($urandom); end
    end
    start = 1'b0;
    if (abort_kind != 0) begin
      check("abort_reached", 64'(idx), 64'(abort_at));
      @(posedge clk); #1;
      if (abort_kind == 1) free_weight_buffer = 1'b1; else rst_n = 1'b1;
      @(posedge clk); #1;
      free_weight_buffer = 1'b0; rst_n = 1'b0;
      check("abort_valid", mem_data_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_rd_en", sram_rd_en, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_no_done_before", 64'(dones), 64'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("abort_quiet", {mem_data_valid, done, busy}, 3'b000);
      end
    end else begin
      check("beat_count", 64'(idx), 64'(exp_q.size()));
      check("done_count", 64'(dones), 64'd1);
      check("read_count", 64'(reads), 64'(exp_words));
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("post_quiet", {mem_data_valid, done, busy}, 3'b000);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
  endtask

  initial begin
    logic [7:0] b;
    // Reset state with mem_req asserted.
    rst_n = 1'b1; mem_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", mem_data_valid, 1'b0);
    check("rst_data", weight_data, 64'd0);
    check("rst_rd_en", sram_rd_en, 1'b0);
    check("rst_addr", sram_addr, 16'd0);
    check("rst_busy_done", {busy, done}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_req_valid", mem_data_valid, 1'b0);
    end
    @(posedge clk); #1;

    // MODE4, SRAM[0x100+i] = i, mem_req held high.
    for (int i = 0; i < 256; i++) mem[i] = 64'(i);
    run(2'd3, 16'h0100, 100, 0, 0, -1);
    for (int i = 0; i < 11; i++) if (got_q.size() > i) check("m4_value", got_q[i], 64'(i));

    // MODE1, base 0, byte k = k mod 256.
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 8; j++) begin
        b = 8'(8 * a + j);
        mem[a][63 - 8 * j -: 8] = b;
      end
    end
    run(2'd0, 16'h0000, 100, 0, 0, -1);
    if (got_q.size() == 86) begin
      check("m1_beat0", got_q[0], 64'h0001020304050607);
      check("m1_beat1", got_q[1], 64'h08090A0000000000);
      check("m1_beat2", got_q[2], 64'h0B0C0D0E0F101112);
      check("m1_beat3", got_q[3], 64'h1314150000000000);
      check("m1_last", got_q[85], 64'hD6D7D80000000000);
    end else check("m1_size", 64'(got_q.size()), 64'd86);

    // MODE3 with 50% mem_req and a start pulse while busy.
    fill_random();
    run(2'd2, 16'(($urandom & 16'hFF00) | 16'h0040), 50, 0, 0, 5);

    // Reset after 5 beats of MODE3, then restart from the same base.
    fill_random();
    run(2'd2, 16'h2230, 100, 5, 2, -1);
    run(2'd2, 16'h2230, 100, 0, 0, -1);

    // Flush at beat 30 of MODE2, then a full restart.
    fill_random();
    run(2'd1, 16'h0310, 100, 30, 1, -1);
    run(2'd1, 16'h0310, 70, 0, 0, -1);

    // start together with free_weight_buffer stays idle.
    reads = 0;
    start = 1'b1; free_weight_buffer = 1'b1; mem_req = 1'b1;
    #1;
    check("start_free_rd_en", sram_rd_en, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; free_weight_buffer = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("start_free_idle", {mem_data_valid, busy, done}, 3'b000);
    end
    check("start_free_reads", 64'(reads), 64'd0);
    @(posedge clk); #1;

    // Random transfers, including an address range that wraps through zero.
    fill_random();
    run(2'd2, 16'hFFF8, 80, 0, 0, -1);
    for (int n = 0; n < 4; n++) begin
      fill_random();
      run(2'($urandom), 16'($urandom), 30 + 20 * n, 0, 0, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
